// File: rtl/regfile_wr_arbiter_if.sv
// Writeback-source request bundle for the register-file write-port arbiter.
// The master side is the writeback sources and the slave side is the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    i_req_valid;
  logic [N_REQ-1:0]    i_req_lock;
  logic [5*N_REQ-1:0]  i_req_waddr;
  logic [32*N_REQ-1:0] i_req_wdata;
  logic [N_REQ-1:0]    o_req_ready;

  modport master (
    output i_req_valid, i_req_lock, i_req_waddr, i_req_wdata,
    input  o_req_ready
  );

  modport slave (
    input  i_req_valid, i_req_lock, i_req_waddr, i_req_wdata,
    output o_req_ready
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port among up to four writeback sources, with an optional bounded lock.
// Define RR_ARB_EN for round-robin arbitration; if it is left undefined, the lowest valid index wins.
module regfile_wr_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_stall,
  regfile_wr_arbiter_if.slave req_if,
  output logic                o_we,
  output logic [4:0]          o_waddr,
  output logic [31:0]         o_wdata,
  output logic [1:0]          o_grant_id,
  output logic                o_locked
);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_owner, w_owner_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;

  logic [3:0]  w_valid4;
  logic [3:0]  w_lock4;
  logic [4:0]  w_addr4 [4];
  logic [31:0] w_data4 [4];
  logic [3:0]  w_ready4;
  logic [1:0]  w_win;
  logic        w_win_vld;
  logic [1:0]  w_sel;
  logic        w_hs;
  logic        w_force;

`ifdef RR_ARB_EN
  logic [1:0]  r_ptr;
  logic [1:0]  w_ptr_nxt;
  logic [2:0]  w_idx;
`endif

  // Pad the request bundle to four slots so index arithmetic stays 2 bits wide.
  always_comb begin
    w_valid4 = '0;
    w_lock4  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_addr4[k[1:0]] = '0;
      w_data4[k[1:0]] = '0;
    end
    w_valid4[N_REQ-1:0] = req_if.i_req_valid;
    w_lock4[N_REQ-1:0]  = req_if.i_req_lock;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_addr4[k[1:0]] = req_if.i_req_waddr[5*k +: 5];
      w_data4[k[1:0]] = req_if.i_req_wdata[32*k +: 32];
    end
  end

`ifdef RR_ARB_EN
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + 3'(k);
      if (w_idx >= 3'(N_REQ)) w_idx = w_idx - 3'(N_REQ);
      if (!w_win_vld && w_valid4[w_idx[1:0]]) begin
        w_win     = w_idx[1:0];
        w_win_vld = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_win_vld && w_valid4[k[1:0]]) begin
        w_win     = k[1:0];
        w_win_vld = 1'b1;
      end
    end
  end
`endif

  assign w_sel = (r_state == ST_ARB) ? w_win : r_owner;

  always_comb begin
    w_ready4 = '0;
    if (i_rst_n && !i_stall) begin
      if (r_state == ST_ARB) begin
        if (w_win_vld) w_ready4[w_win] = 1'b1;
      end else begin
        w_ready4[r_owner] = w_valid4[r_owner];
      end
    end
  end

  assign req_if.o_req_ready = w_ready4[N_REQ-1:0];
  assign w_hs    = |w_ready4;
  assign w_force = (r_state == ST_LOCKED) && (r_cnt == 8'(MAX_LOCK - 1));

  // Forced release also applies in a stalled cycle. This ensures the lock cannot outlive MAX_LOCK cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_ARB: begin
        if (w_hs && w_lock4[w_sel]) begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = w_sel;
          w_cnt_nxt   = '0;
        end
      end
      ST_LOCKED: begin
        w_cnt_nxt = r_cnt + 8'd1;
        if ((w_hs && !w_lock4[w_sel]) || w_force) begin
          w_state_nxt = ST_ARB;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_ARB;
      r_owner    <= '0;
      r_cnt      <= '0;
      o_we       <= 1'b0;
      o_waddr    <= '0;
      o_wdata    <= '0;
      o_grant_id <= '0;
      o_locked   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_cnt    <= w_cnt_nxt;
      o_locked <= (w_state_nxt == ST_LOCKED);
      o_we     <= w_hs && (w_addr4[w_sel] != '0);
      if (w_hs) begin
        o_waddr    <= w_addr4[w_sel];
        o_wdata    <= w_data4[w_sel];
        o_grant_id <= w_sel;
      end
    end
  end

`ifdef RR_ARB_EN
  assign w_ptr_nxt = (w_sel == 2'(N_REQ - 1)) ? 2'd0 : w_sel + 2'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_hs || w_force) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`endif

endmodule
